// File: rtl/capture_trigger_packer.sv
// Logic-analyzer capture front end: masked level/edge trigger at sample resolution,
// minimum pre-trigger depth and post-trigger word count feeding a capture buffer.
module capture_trigger_packer #(
    parameter int CHANNELS = 8,
    parameter int LANES    = 8,
    parameter int CNT_W    = 24,
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int DATA_W  = CHANNELS * LANES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic [CHANNELS-1:0] trig_mask,
    input  logic [CHANNELS-1:0] trig_value,
    input  logic                trig_edge,
    input  logic [CNT_W-1:0]    pre_words,
    input  logic [CNT_W-1:0]    post_words,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [2:0]          state,
    output logic                triggered,
    output logic [CNT_W-1:0]    trig_word,
    output logic [LANE_W-1:0]   trig_lane,
    output logic                overflow
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    pre_len_q, pre_len_d;
    logic [CNT_W-1:0]    post_len_q, post_len_d;
    logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
    logic                prev_match_q, prev_match_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                triggered_q, triggered_d;
    logic [CNT_W-1:0]    trig_word_q, trig_word_d;
    logic [LANE_W-1:0]   trig_lane_q, trig_lane_d;
    logic                overflow_q, overflow_d;

    logic [LANES-1:0]    match;
    logic [LANES-1:0]    hit;
    logic [LANE_W-1:0]   hit_lane;
    logic [CNT_W-1:0]    cnt_inc;
    logic                reg_free;

    // Lane 0's edge reference is the last sample of the previously accepted word.
    always_comb begin
        match    = '0;
        hit      = '0;
        hit_lane = '0;
        for (int l = 0; l < LANES; l++) begin
            match[l] = ((in_data[CHANNELS*l +: CHANNELS] & trig_mask) == (trig_value & trig_mask));
        end
        hit[0] = match[0] & (~trig_edge | ~prev_match_q);
        for (int l = 1; l < LANES; l++) begin
            hit[l] = match[l] & (~trig_edge | ~match[l-1]);
        end
        for (int l = LANES - 1; l >= 0; l--) begin
            if (hit[l]) hit_lane = LANE_W'(l);
        end
    end

    assign cnt_inc  = word_cnt_q + CNT_W'(1);
    assign reg_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        post_cnt_d   = post_cnt_q;
        prev_match_d = prev_match_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        triggered_d  = triggered_q;
        trig_word_d  = trig_word_q;
        trig_lane_d  = trig_lane_q;
        overflow_d   = overflow_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        word_cnt_d   = '0;
                        triggered_d  = 1'b0;
                        trig_word_d  = '0;
                        trig_lane_d  = '0;
                        overflow_d   = 1'b0;
                        out_last_d   = 1'b0;
                        prev_match_d = 1'b0;
                        pre_len_d    = pre_words;
                        post_len_d   = post_words;
                        state_d      = (pre_words == '0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE, ST_WAIT, ST_POST: begin
                    if (in_valid && !reg_free) begin
                        overflow_d = 1'b1;
                    end else if (in_valid) begin
                        out_data_d   = in_data;
                        out_valid_d  = 1'b1;
                        out_last_d   = 1'b0;
                        word_cnt_d   = cnt_inc;
                        prev_match_d = match[LANES-1];
                        case (state_q)
                            ST_PRE: begin
                                if (cnt_inc == pre_len_q) state_d = ST_WAIT;
                            end
                            ST_WAIT: begin
                                if (|hit) begin
                                    triggered_d = 1'b1;
                                    trig_word_d = word_cnt_q;
                                    trig_lane_d = hit_lane;
                                    // post_words of 0 or 1 both end the capture on the trigger word.
                                    if (post_len_q <= CNT_W'(1)) begin
                                        out_last_d = 1'b1;
                                        state_d    = ST_DONE;
                                    end else begin
                                        post_cnt_d = post_len_q - CNT_W'(1);
                                        state_d    = ST_POST;
                                    end
                                end
                            end
                            ST_POST: begin
                                post_cnt_d = post_cnt_q - CNT_W'(1);
                                if (post_cnt_q == CNT_W'(1)) begin
                                    out_last_d = 1'b1;
                                    state_d    = ST_DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            post_cnt_q   <= '0;
            prev_match_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            triggered_q  <= 1'b0;
            trig_word_q  <= '0;
            trig_lane_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            pre_len_q    <= pre_len_d;
            post_len_q   <= post_len_d;
            post_cnt_q   <= post_cnt_d;
            prev_match_q <= prev_match_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            triggered_q  <= triggered_d;
            trig_word_q  <= trig_word_d;
            trig_lane_q  <= trig_lane_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign state     = state_q;
    assign triggered = triggered_q;
    assign trig_word = trig_word_q;
    assign trig_lane = trig_lane_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_capture_trigger_packer.sv
// Scoreboard bench for capture_trigger_packer: directed captures push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_capture_trigger_packer;

    localparam int CHANNELS = 8;
    localparam int LANES    = 8;
    localparam int CNT_W    = 24;
    localparam int DATA_W   = CHANNELS * LANES;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                arm = 1'b0;
    logic                abort = 1'b0;
    logic [CHANNELS-1:0] trig_mask = '0;
    logic [CHANNELS-1:0] trig_value = '0;
    logic                trig_edge = 1'b0;
    logic [CNT_W-1:0]    pre_words = '0;
    logic [CNT_W-1:0]    post_words = '0;
    logic [DATA_W-1:0]   in_data = '0;
    logic                in_valid = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                out_last;
    logic [2:0]          state;
    logic                triggered;
    logic [CNT_W-1:0]    trig_word;
    logic [2:0]          trig_lane;
    logic                overflow;

    capture_trigger_packer #(
        .CHANNELS(CHANNELS),
        .LANES(LANES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .arm(arm),
        .abort(abort),
        .trig_mask(trig_mask),
        .trig_value(trig_value),
        .trig_edge(trig_edge),
        .pre_words(pre_words),
        .post_words(post_words),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .state(state),
        .triggered(triggered),
        .trig_word(trig_word),
        .trig_lane(trig_lane),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Each lane byte carries a word tag and lane number; bit 0 (ch0) is the trigger channel.
    function automatic logic [DATA_W-1:0] makeWord(input int idx, input logic [7:0] ch0);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            w[8*l +: 8] = {idx[3:0], l[2:0], ch0[l]};
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic valid, input logic ready,
                                 input logic expEmit, input logic expLast);
        exp_t e;
        @(posedge clk);
        #1;
        arm       = 1'b0;
        abort     = 1'b0;
        in_data   = data;
        in_valid  = valid;
        out_ready = ready;
        if (expEmit) begin
            e.last = expLast;
            e.data = data;
            expQ.push_back(e);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic armCapture(input int pre, input int post, input logic [7:0] mask,
                              input logic [7:0] value, input logic edgeMode);
        @(posedge clk);
        #1;
        arm        = 1'b1;
        abort      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        pre_words  = CNT_W'(pre);
        post_words = CNT_W'(post);
        trig_mask  = mask;
        trig_value = value;
        trig_edge  = edgeMode;
    endtask

    task automatic abortPulse();
        @(posedge clk);
        #1;
        arm       = 1'b0;
        abort     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input int expState, input logic expTrig,
                               input int expWord, input int expLane, input logic expOvf);
        idleCycles(3);
        checkOutput({tag, " state"}, 64'(state), 64'(expState));
        checkOutput({tag, " triggered"}, 64'(triggered), 64'(expTrig));
        checkOutput({tag, " trig_word"}, 64'(trig_word), 64'(expWord));
        checkOutput({tag, " trig_lane"}, 64'(trig_lane), 64'(expLane));
        checkOutput({tag, " overflow"}, 64'(overflow), 64'(expOvf));
    endtask

    // Monitor: every handshake must match the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no output", out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #23;
        checkOutput("reset state", 64'(state), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_last", 64'(out_last), 64'd0);
        checkOutput("reset triggered", 64'(triggered), 64'd0);
        checkOutput("reset trig_word", 64'(trig_word), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] level trigger, pre=2 post=3");
        armCapture(2, 3, 8'h01, 8'h01, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] c;
            c = (k < 4) ? 8'h00 : (k == 4) ? 8'hE0 : 8'hFF;
            applyStimulus(makeWord(k, c), 1'b1, 1'b1, k < 7, k == 6);
        end
        checkStatus("level", 4, 1'b1, 4, 5, 1'b0);

        $display("[TB] edge across word boundary");
        armCapture(0, 2, 8'h01, 8'h01, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] c;
            c = (k == 3) ? 8'h80 : (k == 4) ? 8'hFF : 8'h00;
            applyStimulus(makeWord(k + 16, c), 1'b1, 1'b1, k < 5, k == 4);
        end
        checkStatus("edge_boundary", 4, 1'b1, 3, 7, 1'b0);

        $display("[TB] edge with level already high at arm");
        armCapture(0, 1, 8'h01, 8'h01, 1'b1);
        applyStimulus(makeWord(32, 8'hFF), 1'b1, 1'b1, 1'b1, 1'b1);
        checkStatus("edge_first", 4, 1'b1, 0, 0, 1'b0);

        $display("[TB] edge continuation from PRE word is not an edge");
        armCapture(1, 1, 8'h01, 8'h01, 1'b1);
        applyStimulus(makeWord(40, 8'h80), 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(makeWord(41, 8'h23), 1'b1, 1'b1, 1'b1, 1'b1);
        checkStatus("edge_cont", 4, 1'b1, 1, 5, 1'b0);

        $display("[TB] pre gating, pre=5");
        armCapture(5, 1, 8'h01, 8'h01, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(makeWord(k + 48, 8'hFF), 1'b1, 1'b1, 1'b1, k == 5);
        end
        checkStatus("pre_gate", 4, 1'b1, 5, 0, 1'b0);

        $display("[TB] backpressure drops two words");
        armCapture(0, 2, 8'h01, 8'h01, 1'b0);
        applyStimulus(makeWord(64, 8'h00), 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(makeWord(65, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeWord(66, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeWord(67, 8'h00), 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(makeWord(68, 8'h10), 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(makeWord(69, 8'h00), 1'b1, 1'b1, 1'b1, 1'b1);
        checkStatus("backpressure", 4, 1'b1, 2, 4, 1'b1);

        $display("[TB] post=0 pre=0 mask=0");
        armCapture(0, 0, 8'h00, 8'hAA, 1'b0);
        applyStimulus(makeWord(80, 8'h00), 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(makeWord(81, 8'h00), 1'b1, 1'b1, 1'b0, 1'b0);
        checkStatus("single", 4, 1'b1, 0, 0, 1'b0);

        $display("[TB] abort in POST with pending word, then rearm");
        armCapture(0, 5, 8'h00, 8'h00, 1'b0);
        applyStimulus(makeWord(96, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeWord(97, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_abort state", 64'(state), 64'd3);
        abortPulse();
        @(posedge clk);
        #2;
        checkOutput("abort out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort out_last", 64'(out_last), 64'd0);
        checkOutput("abort state", 64'(state), 64'd0);
        checkOutput("abort triggered hold", 64'(triggered), 64'd1);
        checkOutput("abort overflow hold", 64'(overflow), 64'd1);
        armCapture(1, 1, 8'h01, 8'h01, 1'b0);
        applyStimulus(makeWord(100, 8'hFF), 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rearm triggered", 64'(triggered), 64'd0);
        checkOutput("rearm overflow", 64'(overflow), 64'd0);
        checkOutput("rearm state", 64'(state), 64'd1);
        applyStimulus(makeWord(101, 8'h04), 1'b1, 1'b1, 1'b1, 1'b1);
        checkStatus("rearm", 4, 1'b1, 1, 2, 1'b0);

        idleCycles(4);
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_trigger_packer.md
Name: capture_trigger_packer

Overview:
- Consumes deserialized logic-analyzer samples in the 62.5 MHz capture domain: LANES samples of CHANNELS bits per clock, taken at 500 MHz by the sampling PLL and SERDES front end.
- Detects a masked level or edge trigger at single-sample resolution and enforces a minimum pre-trigger depth.
- Streams words to the downstream circular capture buffer until the post-trigger count is met, then reports where the trigger fell.

Parameters:
- CHANNELS, 8, probe channels per sample
- LANES, 8, samples per clock word (500 MHz / 62.5 MHz)
- CNT_W, 24, width of word counters and pre/post lengths

Ports:
- clk  in  1  capture-domain clock (62.5 MHz)
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE
- abort  in  1  single-cycle pulse; returns to IDLE from any state
- trig_mask  in  CHANNELS  1 = channel participates in trigger
- trig_value  in  CHANNELS  required level of masked channels
- trig_edge  in  1  0 = level trigger, 1 = entry-edge trigger
- pre_words  in  CNT_W  minimum words emitted before trigger is accepted
- post_words  in  CNT_W  words emitted from the trigger word inclusive; 0 treated as 1
- in_data  in  CHANNELS*LANES  lane l at bits [CHANNELS*(l+1)-1 : CHANNELS*l]; lane 0 is oldest
- in_valid  in  1  in_data valid this cycle; source cannot stall
- out_data  out  CHANNELS*LANES  registered copy of accepted word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  marks final word of capture
- state  out  3  0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
- triggered  out  1  sticky; trigger seen this capture
- trig_word  out  CNT_W  index of word containing trigger (word 0 = first after arm)
- trig_lane  out  clog2(LANES)  lane of trigger sample within trig_word
- overflow  out  1  sticky; a word was dropped due to backpressure

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, previous-match flag 0.
- Per-sample match: m[l] = ((lane l & trig_mask) == (trig_value & trig_mask)). All-zero mask matches every sample.
- Level mode: hit[l] = m[l].
- Edge mode: hit[l] = m[l] & !m[l-1]. For lane 0, m[-1] is the registered m[LANES-1] of the previous accepted word. That flag is cleared on arm, so a match on the very first sample counts as an edge.
- Trigger lane: the lowest l with hit[l].
- Word acceptance: a word is accepted when in_valid and state is PRE, WAIT or POST, and the output register is free (!out_valid | out_ready). Otherwise, in an active state, the word is dropped, overflow is set, and word_cnt does not advance. The previous-match flag updates only on accepted words.
- Latency: accepted word appears on out_data/out_valid the next cycle. out_valid holds until out_ready. Same-cycle accept and drain is allowed.
- word_cnt: cleared on arm; increments per accepted word; wraps modulo 2^CNT_W.
- IDLE/DONE: arm -> PRE. Clears word_cnt, triggered, trig_word, trig_lane, overflow and out_last. Latches pre_words and post_words; config changes mid-capture are ignored. arm in PRE, WAIT or POST is ignored.
- PRE: accept words. When word_cnt (after the increment) reaches the latched pre_words, go to WAIT. pre_words = 0 enters WAIT directly on arm, so the first word is trigger-eligible.
- WAIT: accepted word with any hit[l]:
  - set triggered; trig_word = index of that word; trig_lane = lowest hit lane;
  - load post_cnt = max(post_words, 1) - 1;
  - if post_cnt = 0, emit this word with out_last and go to DONE; else go to POST.
  - Hits in words that are dropped or not yet eligible (PRE) are ignored.
- POST: each accepted word decrements post_cnt. The word that takes post_cnt to 0 carries out_last; then go to DONE. No triggering in POST.
- DONE: no further words accepted. A pending out_valid still drains normally. triggered, trig_word and trig_lane hold until the next arm.
- abort (any state): next cycle state IDLE, out_valid 0 (pending word discarded), out_last 0. Status flags hold. abort wins over a simultaneous arm.

Test Plan:
- Level trigger, pre_words=2, post_words=3, mask=0x01, value=0x01, ch0 rises in word 4 lane 5, out_ready=1 -> words 0..6 emitted; trig_word=4, trig_lane=5; out_last on word 6; state DONE.
- Edge across boundary: ch0 high in lane 7 of word 3 and lane 0 of word 4, trig_edge=1 -> trig_word=3, trig_lane=7; a level already high at arm triggers at word 0 lane 0.
- pre gating: pre_words=5, match present from word 0 -> trigger at word 5 lane 0, never earlier.
- Backpressure: out_ready=0 for 3 cycles with continuous in_valid -> overflow=1, exactly 2 words dropped, word_cnt advances only on accepted words.
- post_words=0, pre_words=0, mask=0 -> single word emitted with out_last; trig_word=0, trig_lane=0.
- abort during POST with out_valid=1, then arm -> out_valid low the next cycle; new capture restarts word_cnt at 0 and clears triggered and overflow.
